// File: rtl/vbuf_pkg.sv
// rtl/vbuf_pkg.sv - shared state type and buffer geometry for the vertical ifmap buffer
package vbuf_pkg;

  localparam int COL_NUM    = 32;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_WAIT,
    PE_WAIT,
    SHIFT,
    FIN
  } vbuf_state_e;

endpackage

// File: rtl/vbuf_rd_lat_pipe.sv
// rtl/vbuf_rd_lat_pipe.sv - RD_LAT-stage delay line aligning glb_rd_en with returned GLB data
module vbuf_rd_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic delayed
);

  logic [RD_LAT-1:0] stages;

  // Shift the read strobe through RD_LAT stages; reset empties the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | RD_LAT'(strobe);
    end
  end

  assign delayed = stages[RD_LAT-1];

endmodule

// File: rtl/vbuf_ctrl.sv
// rtl/vbuf_ctrl.sv - per-tile GLB read / buffer load / shift-out sequencer (optional VBUF_CTRL_PERF_EN stall counter)
module vbuf_ctrl
  import vbuf_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 16,
  parameter int TILE_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              pe_ready,
  output logic              glb_rd_en,
  output logic [ADDR_W-1:0] glb_rd_addr,
  output logic              store_ifmap_f,
  output logic              ifmap_out_f,
  output logic              busy,
  output logic              done
`ifdef VBUF_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int COL_W = $clog2(COL_NUM);
  localparam int CNT_W = 8;

  vbuf_state_e       state;
  vbuf_state_e       state_nx;
  logic [COL_W-1:0]  col;
  logic [TILE_W-1:0] tile;
  logic [TILE_W-1:0] num_tiles;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              col_last;
  logic              shift_last;
  logic              tile_last;

  assign col_last   = (col == COL_W'(COL_NUM - 1));
  assign shift_last = (cnt == CNT_W'(FIFO_DEPTH - 1));
  assign tile_last  = ((tile + TILE_W'(1)) == num_tiles);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; LD_WAIT covers the read-latency tail so PE_WAIT lands on the last store.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (cfg_num_tiles == '0) ? FIN : RD;
        end
      end
      RD: begin
        if (col_last) begin
          state_nx = (RD_LAT > 1) ? LD_WAIT : PE_WAIT;
        end
      end
      LD_WAIT: begin
        if (cnt == CNT_W'(RD_LAT - 2)) begin
          state_nx = PE_WAIT;
        end
      end
      PE_WAIT: begin
        if (pe_ready) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_last) begin
          state_nx = tile_last ? FIN : RD;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Config capture, column/tile counters and the running GLB address (base + tile*COL_NUM + col).
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      num_tiles <= '0;
      tile      <= '0;
      col       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= cfg_base_addr;
            num_tiles <= cfg_num_tiles;
            tile      <= '0;
            col       <= '0;
            cnt       <= '0;
          end
        end
        RD: begin
          addr <= addr + ADDR_W'(1);
          col  <= col_last ? '0 : col + COL_W'(1);
          cnt  <= '0;
        end
        LD_WAIT: begin
          cnt <= cnt + CNT_W'(1);
        end
        PE_WAIT: begin
          cnt <= '0;
        end
        SHIFT: begin
          if (shift_last) begin
            cnt  <= '0;
            tile <= tile + TILE_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  vbuf_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .strobe  (glb_rd_en),
    .delayed (store_ifmap_f)
  );

  assign glb_rd_en   = (state == RD);
  assign glb_rd_addr = addr;
  assign ifmap_out_f = (state == SHIFT);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

`ifdef VBUF_CTRL_PERF_EN
  // Saturating count of PE_WAIT cycles spent with the PE array not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      perf_stall_cnt <= '0;
    end else if (state == PE_WAIT && !pe_ready && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vbuf_ctrl.sv
// tb/tb_vbuf_ctrl.sv - directed self-checking bench for vbuf_ctrl (checks perf counter when VBUF_CTRL_PERF_EN)
module tb_vbuf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_base_addr;
  logic [9:0]  cfg_num_tiles;
  logic        pe_ready;
  logic        glb_rd_en;
  logic [15:0] glb_rd_addr;
  logic        store_ifmap_f;
  logic        ifmap_out_f;
  logic        busy;
  logic        done;
`ifdef VBUF_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  vbuf_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_tiles (cfg_num_tiles),
    .pe_ready      (pe_ready),
    .glb_rd_en     (glb_rd_en),
    .glb_rd_addr   (glb_rd_addr),
    .store_ifmap_f (store_ifmap_f),
    .ifmap_out_f   (ifmap_out_f),
    .busy          (busy),
    .done          (done)
`ifdef VBUF_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int rd_cnt, first_rd, store_cnt, first_store, last_store, store_rises;
  int shift_cnt, first_shift, shift_rises, overlap, done_cnt, done_cyc, busy_cnt;
  int timeout;
  logic post_rst_any;
  logic [15:0] addr_log[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 carries start; each later iteration samples the cycle after the next edge.
  task automatic run(input logic [15:0] base, input logic [9:0] tiles, input int stall_at,
                     input int stall_len, input int restart_at, input int reset_at);
    logic prev_store, prev_shift, finished;
    rd_cnt = 0; first_rd = -1; store_cnt = 0; first_store = -1; last_store = -1; store_rises = 0;
    shift_cnt = 0; first_shift = -1; shift_rises = 0; overlap = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; timeout = 0; post_rst_any = 1'b0;
    addr_log.delete();
    prev_store = 1'b0; prev_shift = 1'b0; finished = 1'b0;
    cfg_base_addr = base;
    cfg_num_tiles = tiles;
    for (int c = 0; c < 400; c++) begin
      start    = (c == 0) || (c == restart_at);
      reset    = (reset_at >= 0) && (c == reset_at);
      pe_ready = !((stall_at >= 0) && (c >= stall_at) && (c < stall_at + stall_len));
      if (glb_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
        addr_log.push_back(glb_rd_addr);
      end
      if (store_ifmap_f) begin
        store_cnt++;
        if (first_store < 0) first_store = c;
        last_store = c;
        if (!prev_store) store_rises++;
      end
      if (ifmap_out_f) begin
        shift_cnt++;
        if (first_shift < 0) first_shift = c;
        if (!prev_shift) shift_rises++;
      end
      if (store_ifmap_f && ifmap_out_f) overlap++;
      if (busy) busy_cnt++;
      if (done_cnt > 0 && !done) begin
        finished = 1'b1;
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      prev_store = store_ifmap_f;
      prev_shift = ifmap_out_f;
      if (reset_at >= 0 && c == reset_at + 1) begin
        post_rst_any = glb_rd_en | store_ifmap_f | ifmap_out_f | busy | done | (glb_rd_addr != 16'h0);
        finished = 1'b1;
        break;
      end
      step();
    end
    start    = 1'b0;
    reset    = 1'b0;
    pe_ready = 1'b1;
    if (!finished) timeout = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; pe_ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({glb_rd_en, store_ifmap_f, ifmap_out_f, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000", {glb_rd_en, store_ifmap_f, ifmap_out_f, busy, done});
    end
    checks++;
    if (glb_rd_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h want=0000", glb_rd_addr);
    end
`ifdef VBUF_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got=%0d want=0", perf_stall_cnt);
    end
`endif
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy got=%b want=0", busy);
    end
  endtask

  task automatic test_tile_load;
    int bad;
    run(16'h0100, 10'd1, -1, 0, -1, -1);
    checks++; if (timeout != 0) begin failures++; $display("FAIL load_timeout got=%0d want=0", timeout); end
    checks++; if (first_rd != 1) begin failures++; $display("FAIL load_first_rd got=%0d want=1", first_rd); end
    checks++; if (rd_cnt != 32) begin failures++; $display("FAIL load_rd_cnt got=%0d want=32", rd_cnt); end
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 16'h0100 + 16'(i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL load_addr_seq got=%0d bad want=0", bad); end
    if (addr_log.size() == 32) begin
      checks++;
      if (addr_log[31] !== 16'h011F) begin failures++; $display("FAIL load_last_addr got=%h want=011f", addr_log[31]); end
    end
    checks++; if (first_store != 3) begin failures++; $display("FAIL load_first_store got=%0d want=3", first_store); end
    checks++; if (last_store != 34) begin failures++; $display("FAIL load_last_store got=%0d want=34", last_store); end
    checks++; if (store_cnt != 32 || store_rises != 1) begin failures++; $display("FAIL load_store_run got=%0d/%0d want=32/1", store_cnt, store_rises); end
    checks++; if (first_shift != 35) begin failures++; $display("FAIL load_first_shift got=%0d want=35", first_shift); end
    checks++; if (shift_cnt != 4) begin failures++; $display("FAIL load_shift_cnt got=%0d want=4", shift_cnt); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL load_overlap got=%0d want=0", overlap); end
    checks++; if (done_cnt != 1 || done_cyc != 39) begin failures++; $display("FAIL load_done got=%0d@%0d want=1@39", done_cnt, done_cyc); end
    checks++; if (busy_cnt != 39) begin failures++; $display("FAIL load_busy_cycles got=%0d want=39", busy_cnt); end
  endtask

  task automatic test_pe_stall;
    run(16'h0100, 10'd2, 34, 10, -1, -1);
    checks++; if (timeout != 0) begin failures++; $display("FAIL stall_timeout got=%0d want=0", timeout); end
    checks++; if (first_shift != 45) begin failures++; $display("FAIL stall_first_shift got=%0d want=45", first_shift); end
    checks++; if (shift_cnt != 8 || shift_rises != 2) begin failures++; $display("FAIL stall_shift_runs got=%0d/%0d want=8/2", shift_cnt, shift_rises); end
    checks++; if (rd_cnt != 64) begin failures++; $display("FAIL stall_rd_cnt got=%0d want=64", rd_cnt); end
    if (addr_log.size() == 64) begin
      checks++;
      if (addr_log[32] !== 16'h0120 || addr_log[63] !== 16'h013F) begin
        failures++; $display("FAIL stall_tile1_addr got=%h..%h want=0120..013f", addr_log[32], addr_log[63]);
      end
    end
    checks++; if (store_cnt != 64 || store_rises != 2) begin failures++; $display("FAIL stall_store_runs got=%0d/%0d want=64/2", store_cnt, store_rises); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL stall_overlap got=%0d want=0", overlap); end
    checks++; if (done_cyc != 87) begin failures++; $display("FAIL stall_done_cyc got=%0d want=87", done_cyc); end
`ifdef VBUF_CTRL_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd10) begin failures++; $display("FAIL stall_perf got=%0d want=10", perf_stall_cnt); end
`endif
  endtask

  task automatic test_zero_tiles;
    run(16'h0200, 10'd0, -1, 0, -1, -1);
    checks++; if (timeout != 0) begin failures++; $display("FAIL zero_timeout got=%0d want=0", timeout); end
    checks++; if (rd_cnt + store_cnt + shift_cnt != 0) begin failures++; $display("FAIL zero_activity got=%0d/%0d/%0d want=0/0/0", rd_cnt, store_cnt, shift_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 1) begin failures++; $display("FAIL zero_done got=%0d@%0d want=1@1", done_cnt, done_cyc); end
    checks++; if (busy_cnt != 1) begin failures++; $display("FAIL zero_busy got=%0d want=1", busy_cnt); end
`ifdef VBUF_CTRL_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd0) begin failures++; $display("FAIL zero_perf_cleared got=%0d want=0", perf_stall_cnt); end
`endif
  endtask

  task automatic test_ignored_start;
    run(16'h0300, 10'd3, -1, 0, 5, -1);
    checks++; if (timeout != 0) begin failures++; $display("FAIL ign_timeout got=%0d want=0", timeout); end
    checks++; if (rd_cnt != 96) begin failures++; $display("FAIL ign_rd_cnt got=%0d want=96", rd_cnt); end
    if (addr_log.size() == 96) begin
      checks++;
      if (addr_log[0] !== 16'h0300 || addr_log[95] !== 16'h035F) begin
        failures++; $display("FAIL ign_addr got=%h..%h want=0300..035f", addr_log[0], addr_log[95]);
      end
    end
    checks++; if (store_rises != 3) begin failures++; $display("FAIL ign_store_runs got=%0d want=3", store_rises); end
    checks++; if (done_cnt != 1 || done_cyc != 115) begin failures++; $display("FAIL ign_done got=%0d@%0d want=1@115", done_cnt, done_cyc); end
  endtask

  task automatic test_mid_reset;
    run(16'h0100, 10'd1, -1, 0, -1, 18);
    checks++; if (rd_cnt != 18) begin failures++; $display("FAIL mrst_rd_before got=%0d want=18", rd_cnt); end
    checks++; if (post_rst_any !== 1'b0) begin failures++; $display("FAIL mrst_outputs got=%b want=0", post_rst_any); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL mrst_done got=%0d want=0", done_cnt); end
    run(16'h0100, 10'd1, -1, 0, -1, -1);
    checks++; if (rd_cnt != 32 || first_rd != 1) begin failures++; $display("FAIL mrst_rerun_rd got=%0d@%0d want=32@1", rd_cnt, first_rd); end
    if (addr_log.size() > 0) begin
      checks++;
      if (addr_log[0] !== 16'h0100) begin failures++; $display("FAIL mrst_rerun_addr got=%h want=0100", addr_log[0]); end
    end
    checks++; if (store_cnt != 32 || store_rises != 1) begin failures++; $display("FAIL mrst_rerun_store got=%0d/%0d want=32/1", store_cnt, store_rises); end
    checks++; if (done_cyc != 39) begin failures++; $display("FAIL mrst_rerun_done got=%0d want=39", done_cyc); end
  endtask

  task automatic test_addr_wrap;
    run(16'hFFF0, 10'd1, -1, 0, -1, -1);
    checks++; if (rd_cnt != 32) begin failures++; $display("FAIL wrap_rd_cnt got=%0d want=32", rd_cnt); end
    if (addr_log.size() == 32) begin
      checks++;
      if (addr_log[0] !== 16'hFFF0 || addr_log[15] !== 16'hFFFF) begin
        failures++; $display("FAIL wrap_high got=%h..%h want=fff0..ffff", addr_log[0], addr_log[15]);
      end
      checks++;
      if (addr_log[16] !== 16'h0000 || addr_log[31] !== 16'h000F) begin
        failures++; $display("FAIL wrap_low got=%h..%h want=0000..000f", addr_log[16], addr_log[31]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pe_ready = 1'b1;
    cfg_base_addr = 16'h0; cfg_num_tiles = 10'd0;
    test_reset();
    test_tile_load();
    test_pe_stall();
    test_zero_tiles();
    test_ignored_start();
    test_mid_reset();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
